// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared types and constants for the RAM-backed FIFO controller.
// Optional feature macro: RAM_FIFO_HWM_EN (high-water-mark tracking).
//   DATA_WIDTH / ADDR_WIDTH : word and RAM address widths
//   DEPTH                   : RAM words (2**ADDR_WIDTH)
//   level_t                 : occupancy count, one bit wider than an address
//   rd_state_t              : read-sequencer state encoding
package ram_fifo_ctrl_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;

    typedef logic                  bit_t;
    typedef logic [DATA_WIDTH-1:0] DATA_W;
    typedef logic [ADDR_WIDTH-1:0] ADDR_W;
    typedef logic [ADDR_WIDTH:0]   level_t;

    typedef logic [1:0] rd_state_t;
    localparam rd_state_t IDLE  = 2'd0;
    localparam rd_state_t FETCH = 2'd1;
    localparam rd_state_t VALID = 2'd2;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Bundle of producer, consumer and RAM-side signals of the FIFO controller.
// Optional feature macro: RAM_FIFO_HWM_EN adds hwm / hwm_clr.
//   slave  : the controller (drives grants, read stage, RAM controls, status)
//   master : the environment (producers, consumer, RAM read data)
interface ram_fifo_ctrl_if;
    import ram_fifo_ctrl_pkg::*;

    logic [1:0] wr_req;
    DATA_W      wr_data0;
    DATA_W      wr_data1;
    logic [1:0] wr_gnt;
    bit_t       rd_valid;
    bit_t       rd_ready;
    DATA_W      rd_data;
    bit_t       ram_en_w;
    ADDR_W      ram_write_addr;
    DATA_W      ram_data;
    bit_t       ram_en_r;
    ADDR_W      ram_read_addr;
    DATA_W      ram_q;
    level_t     level;
    bit_t       full;
    bit_t       empty;
`ifdef RAM_FIFO_HWM_EN
    level_t     hwm;
    bit_t       hwm_clr;
`endif

    modport slave (
`ifdef RAM_FIFO_HWM_EN
        input  hwm_clr,
        output hwm,
`endif
        input  wr_req, wr_data0, wr_data1, rd_ready, ram_q,
        output wr_gnt, rd_valid, rd_data, ram_en_w, ram_write_addr, ram_data,
        output ram_en_r, ram_read_addr, level, full, empty
    );

    modport master (
`ifdef RAM_FIFO_HWM_EN
        output hwm_clr,
        input  hwm,
`endif
        output wr_req, wr_data0, wr_data1, rd_ready, ram_q,
        input  wr_gnt, rd_valid, rd_data, ram_en_w, ram_write_addr, ram_data,
        input  ram_en_r, ram_read_addr, level, full, empty
    );

endinterface

// File: rtl/ram_fifo_ctrl_rr_arbiter_2.sv
// Two-way round-robin arbiter with a one-hot, same-cycle grant.
//   clk, rst_n : clock, async active-low reset
//   en_i       : grant permitted this cycle
//   req_i      : request per requester, bit0 = requester 0
//   gnt_o      : one-hot grant
module ram_fifo_ctrl_rr_arbiter_2
    import ram_fifo_ctrl_pkg::*;
(
    input  bit_t       clk,
    input  bit_t       rst_n,
    input  bit_t       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    // Index of the most recent winner; resets to 1 so requester 0 wins first.
    bit_t rr_last_q, rr_last_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = rr_last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
        rr_last_d = rr_last_q;
        if (gnt_o != 2'b00) begin
            rr_last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Two-producer, one-consumer FIFO sequencer around an external simple
// dual-port RAM with a 1-cycle registered read.
// Optional feature macro: RAM_FIFO_HWM_EN (hwm output, hwm_clr input).
//   clk    : system clock, also clocks both RAM ports
//   rst_n  : async active-low reset
//   bus_io : producers (wr_req/wr_data0/wr_data1/wr_gnt), consumer
//            (rd_valid/rd_ready/rd_data), RAM controls and status (level/full/empty)
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
(
    input  bit_t                  clk,
    input  bit_t                  rst_n,
    ram_fifo_ctrl_if.slave        bus_io
);

    logic [1:0] gnt;
    bit_t       full;
    bit_t       wr_fire;
    bit_t       issue;
    bit_t       have_word;

    ADDR_W      wr_ptr_q, wr_ptr_d;
    ADDR_W      rd_ptr_q, rd_ptr_d;
    level_t     level_q, level_d;
    rd_state_t  state_q, state_d;
    DATA_W      rd_data_q, rd_data_d;
    bit_t       rd_valid_q, rd_valid_d;

    assign full      = (level_q == level_t'(DEPTH));
    assign wr_fire   = |gnt;
    // level counts committed words only, so a read never hits the word
    // being written in the same cycle.
    assign have_word = (level_q != '0);

    ram_fifo_ctrl_rr_arbiter_2 u_rr_arbiter_2 (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (!full),
        .req_i (bus_io.wr_req),
        .gnt_o (gnt)
    );

    always_comb begin
        issue      = 1'b0;
        state_d    = state_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        case (state_q)
            IDLE: begin
                if (have_word) begin
                    issue   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rd_data_d  = bus_io.ram_q;
                rd_valid_d = 1'b1;
                state_d    = VALID;
            end
            VALID: begin
                if (bus_io.rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (have_word) begin
                        issue   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + ADDR_W'(wr_fire);
        rd_ptr_d = rd_ptr_q + ADDR_W'(issue);
        level_d  = level_q + level_t'(wr_fire) - level_t'(issue);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            state_q    <= IDLE;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus_io.wr_gnt         = gnt;
    assign bus_io.ram_en_w       = wr_fire;
    assign bus_io.ram_write_addr = wr_ptr_q;
    assign bus_io.ram_data       = gnt[1] ? bus_io.wr_data1 : bus_io.wr_data0;
    assign bus_io.ram_en_r       = issue;
    assign bus_io.ram_read_addr  = rd_ptr_q;
    assign bus_io.rd_valid       = rd_valid_q;
    assign bus_io.rd_data        = rd_data_q;
    assign bus_io.level          = level_q;
    assign bus_io.full           = full;
    assign bus_io.empty          = !have_word;

`ifdef RAM_FIFO_HWM_EN
    level_t hwm_q, hwm_d;

    always_comb begin
        hwm_d = hwm_q;
        if (bus_io.hwm_clr) begin
            hwm_d = level_q;
        end else if (level_q > hwm_q) begin
            hwm_d = level_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign bus_io.hwm = hwm_q;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: behavioural RAM, queue-based FIFO
// model checked every cycle, and directed vectors with literal expectations.
module tb_ram_fifo_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ram_fifo_ctrl_if bus ();

    ram_fifo_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: registered read, one cycle latency.
    logic [7:0] mem [16];
    always @(posedge clk) begin
        if (bus.ram_en_w) mem[bus.ram_write_addr] <= bus.ram_data;
        if (bus.ram_en_r) bus.ram_q <= mem[bus.ram_read_addr];
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO model: q holds every accepted word not yet taken by the consumer.
    // stage: 0 = output stage empty, 1 = word fetching, 2 = word presented.
    logic [7:0] q[$];
    logic [7:0] got[$];
    int         stage = 0;
    logic       rr_m = 1'b1;
    logic [3:0] wcnt = '0;
    logic [3:0] rcnt = '0;
    int         lvl;
    logic [1:0] eg;
    logic       ei;
    logic [7:0] wd;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            stage = 0;
            rr_m  = 1'b1;
            wcnt  = '0;
            rcnt  = '0;
        end else begin
            lvl = q.size() - ((stage != 0) ? 1 : 0);
            eg  = 2'b00;
            if (lvl < 16) begin
                case (bus.wr_req)
                    2'b01:   eg = 2'b01;
                    2'b10:   eg = 2'b10;
                    2'b11:   eg = rr_m ? 2'b01 : 2'b10;
                    default: eg = 2'b00;
                endcase
            end
            ei = (lvl > 0) && (stage == 0 || (stage == 2 && bus.rd_ready));
            wd = eg[1] ? bus.wr_data1 : bus.wr_data0;

            chk("m_gnt", bus.wr_gnt, eg);
            chk("m_en_w", bus.ram_en_w, |eg);
            if (eg != 2'b00) begin
                chk("m_waddr", bus.ram_write_addr, wcnt);
                chk("m_wdata", bus.ram_data, wd);
            end
            chk("m_en_r", bus.ram_en_r, ei);
            if (ei) chk("m_raddr", bus.ram_read_addr, rcnt);
            chk("m_rd_valid", bus.rd_valid, stage == 2);
            if (stage == 2) chk("m_rd_data", bus.rd_data, q[0]);
            chk("m_level", bus.level, lvl);
            chk("m_full", bus.full, lvl == 16);
            chk("m_empty", bus.empty, lvl == 0);

            if (stage == 2 && bus.rd_ready) got.push_back(q.pop_front());
            if (eg != 2'b00) begin
                q.push_back(wd);
                rr_m = eg[1];
                wcnt++;
            end
            if (ei) rcnt++;
            if (ei) stage = 1;
            else if (stage == 1) stage = 2;
            else if (stage == 2 && bus.rd_ready) stage = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    int         gcount;
    logic [1:0] g_first [2];
    logic       g0;
    int         sent;
    int         cyc;
    logic       seen;

    initial begin
        bus.wr_req   = 2'b00;
        bus.wr_data0 = '0;
        bus.wr_data1 = '0;
        bus.rd_ready = 1'b0;
`ifdef RAM_FIFO_HWM_EN
        bus.hwm_clr  = 1'b0;
`endif
        #12 rst_n = 1'b1;

        // Reset then idle.
        repeat (10) begin
            smp();
            chk("idle_empty", bus.empty, 1);
            chk("idle_level", bus.level, 0);
            chk("idle_rd_valid", bus.rd_valid, 0);
            chk("idle_gnt", bus.wr_gnt, 0);
            chk("idle_en_w", bus.ram_en_w, 0);
            chk("idle_en_r", bus.ram_en_r, 0);
        end

        // Single write: grant now, rd_valid 3 cycles later.
        step();
        bus.wr_req = 2'b01; bus.wr_data0 = 8'hA5; bus.rd_ready = 1'b1;
        smp();
        chk("single_gnt", bus.wr_gnt, 2'b01);
        chk("single_waddr", bus.ram_write_addr, 0);
        step(); bus.wr_req = 2'b00;
        smp(); chk("single_c1_valid", bus.rd_valid, 0);
        step(); smp(); chk("single_c2_valid", bus.rd_valid, 0);
        step(); smp();
        chk("single_c3_valid", bus.rd_valid, 1);
        chk("single_c3_data", bus.rd_data, 8'hA5);
        step(); smp();
        chk("single_after_valid", bus.rd_valid, 0);
        chk("single_after_empty", bus.empty, 1);

        // Fresh reset so producer 0 wins the first contended grant.
        step(); rst_n = 1'b0; #2 rst_n = 1'b1;

        // Contention with no consumer: 16 words in RAM plus 1 in rd_data.
        step();
        bus.rd_ready = 1'b0; bus.wr_req = 2'b11;
        bus.wr_data0 = 8'h10; bus.wr_data1 = 8'h20;
        gcount = 0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (bus.wr_gnt != 2'b00) begin
                if (gcount < 2) g_first[gcount] = bus.wr_gnt;
                gcount++;
            end
            step();
        end
        smp();
        chk("cont_gnt0", g_first[0], 2'b01);
        chk("cont_gnt1", g_first[1], 2'b10);
        chk("cont_grants", gcount, 17);
        chk("cont_full", bus.full, 1);
        chk("cont_gnt_held", bus.wr_gnt, 0);
        chk("cont_rd_valid", bus.rd_valid, 1);
        chk("cont_first_word", bus.rd_data, 8'h10);

        // Full plus one pop.
        step(); bus.rd_ready = 1'b1;
        smp();
        chk("pop_issue", bus.ram_en_r, 1);
        chk("pop_level_pre", bus.level, 16);
        step(); bus.rd_ready = 1'b0;
        smp();
        chk("pop_level_post", bus.level, 15);
        chk("pop_full_drop", bus.full, 0);
        chk("pop_regrant", bus.wr_gnt, 2'b10);
        step(); smp();
        chk("pop_second_valid", bus.rd_valid, 1);
        chk("pop_second_word", bus.rd_data, 8'h20);

        // Drain.
        step(); bus.wr_req = 2'b00; bus.rd_ready = 1'b1;
        repeat (60) step();
        smp();
        chk("drain_empty", bus.empty, 1);
        chk("drain_rd_valid", bus.rd_valid, 0);

        // Wrap: 40 words through producer 0 with random back-pressure.
        step();
        got.delete();
        sent = 0; cyc = 0;
        bus.wr_data0 = 8'd0; bus.wr_req = 2'b01;
        while (got.size() < 40 && cyc < 2000) begin
            smp();
            g0 = bus.wr_gnt[0];
            step();
            cyc++;
            if (g0) begin
                sent++;
                if (sent < 40) bus.wr_data0 = 8'(sent);
                else bus.wr_req = 2'b00;
            end
            bus.rd_ready = 1'($urandom_range(0, 1));
        end
        chk("wrap_in_time", cyc < 2000, 1);
        chk("wrap_count", got.size(), 40);
        for (int i = 0; i < 40 && i < got.size(); i++) begin
            chk("wrap_order", got[i], i);
        end

        // Async reset while fetching.
        bus.wr_req = 2'b00; bus.rd_ready = 1'b1;
        repeat (6) step();
        bus.rd_ready = 1'b0;
        bus.wr_req = 2'b01; bus.wr_data0 = 8'h01;
        step(); bus.wr_data0 = 8'h02;
        step(); bus.wr_data0 = 8'h03;
        chk("rst_pre_level", bus.level, 1);
        chk("rst_pre_valid", bus.rd_valid, 0);
        bus.wr_req = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_level", bus.level, 0);
        chk("rst_valid", bus.rd_valid, 0);
        chk("rst_empty", bus.empty, 1);
        smp();
        #2 rst_n = 1'b1;
        step();
        bus.wr_req = 2'b01; bus.wr_data0 = 8'h3C; bus.rd_ready = 1'b1;
        step(); bus.wr_req = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            smp();
            if (bus.rd_valid) begin
                seen = 1'b1;
                chk("rst_readback", bus.rd_data, 8'h3C);
            end
        end
        chk("rst_readback_seen", seen, 1);

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
